// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-through data cache.
//   - controller state encoding
//   - line/word/offset geometry
//   - index and tag width derivation from the number of lines
package dcache_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 128;
  localparam int OFFSET_W    = 4;    // 16 bytes per line
  localparam int MASK_W      = 16;   // one enable per byte of a line
  localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

  // LINES must be a power of two and at least 2.
  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return ADDR_W - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag, valid and line storage for the direct-mapped cache.
// Ports:
//   clk, reset    clock, async active-low reset (clears valid bits only)
//   rd_idx        read-port line index; rd_valid/rd_tag/rd_data are combinational
//   wr_en         write strobe: stores wr_tag, sets valid, merges masked bytes
//   wr_idx        write-port line index
//   wr_tag        tag written with the line
//   wr_data       128-bit line data, byte b in bits [8b+7:8b]
//   wr_mask       16-bit byte enables for wr_data
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = index_width(LINES),
  parameter int TAG_W = tag_width(LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask
);

  logic              valid_q [LINES];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [LINE_W-1:0] data_q  [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int b = 0; b < MASK_W; b++) begin
        if (wr_mask[b]) data_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, no-write-allocate data cache.
// Optional feature: define DCACHE_STATS_EN to build the read hit/miss counters;
// otherwise hit_count and miss_count are constant zero.
// Ports:
//   clk, reset                 clock, async active-low reset
//   dcache_addr/din/re/we      CPU request (held stable while stall is high)
//   dcache_dout                registered read word, one cycle after a hit
//   stall                      CPU must hold its request
//   mem_req_valid/ready        memory request handshake
//   mem_req_rw/addr/data/mask  request body: rw=1 write, addr = line address,
//                              data/mask = store word and bytes placed at their lane
//   mem_resp_valid/data        line fill, word 0 in bits [31:0]
//   hit_count, miss_count      read statistics
module dmem_cache
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      dcache_addr,
  input  logic [WORD_W-1:0]      dcache_din,
  input  logic                   dcache_re,
  input  logic [3:0]             dcache_we,
  output logic [WORD_W-1:0]      dcache_dout,
  output logic                   stall,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [LINE_ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0]      mem_req_data,
  output logic [MASK_W-1:0]      mem_req_mask,
  input  logic                   mem_resp_valid,
  input  logic [LINE_W-1:0]      mem_resp_data,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int IDX_W = index_width(LINES);
  localparam int TAG_W = tag_width(LINES);

  state_e            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        lane;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic [WORD_W-1:0] rd_word;
  logic              hit;
  logic              is_store;
  logic              rd_hit_idle;
  logic              fill_we;
  logic              store_we;
  logic              unused_addr_lsb;
  logic [WORD_W-1:0] dout_p1;

  assign idx      = dcache_addr[OFFSET_W +: IDX_W];
  assign tag      = dcache_addr[ADDR_W-1 -: TAG_W];
  assign lane     = dcache_addr[3:2];
  assign is_store = |dcache_we;
  // Sub-word byte position is already encoded in dcache_we.
  assign unused_addr_lsb = ^dcache_addr[1:0];

  dcache_array #(
    .LINES (LINES)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_we | store_we),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (fill_we ? mem_resp_data : mem_req_data),
    .wr_mask  (fill_we ? {MASK_W{1'b1}} : mem_req_mask)
  );

  assign hit     = rd_valid && (rd_tag == tag);
  assign rd_word = rd_data[{lane, 5'b0} +: WORD_W];

  // Request body is a pure function of the held CPU request, so it stays
  // stable for as long as the CPU is stalled.
  assign mem_req_addr = dcache_addr[ADDR_W-1:OFFSET_W];
  assign mem_req_data = {{(LINE_W-WORD_W){1'b0}}, dcache_din} << {lane, 5'b0};
  assign mem_req_mask = {12'b0, dcache_we} << {lane, 2'b0};

  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    rd_hit_idle   = 1'b0;
    fill_we       = 1'b0;
    store_we      = 1'b0;
    case (state)
      IDLE: begin
        if (is_store) begin
          stall     = 1'b1;
          state_nxt = WR_REQ;
        end else if (dcache_re) begin
          if (hit) begin
            rd_hit_idle = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          fill_we   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        if (mem_req_ready) begin
          store_we  = hit;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Store already sent; release the CPU for one cycle without reissuing.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dout_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (rd_hit_idle) dout_p1 <= rd_word;
    end
  end

  assign dcache_dout = dout_p1;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        replay_q;

  // The access replayed right after a refill was already counted as a miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q    <= '0;
      miss_q   <= '0;
      replay_q <= 1'b0;
    end else begin
      if (fill_we) replay_q <= 1'b1;
      else if (state == IDLE) replay_q <= 1'b0;
      if (rd_hit_idle && !replay_q) hit_q <= hit_q + 32'd1;
      if (state == IDLE && state_nxt == RD_REQ) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: directed scoreboard bench for dmem_cache.
// Expected read words are pushed to a queue when a read is issued and popped
// when dcache_dout is sampled; a backing-memory model supplies line fills and
// absorbs write-through stores.
module tb_dmem_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  dcache_addr;
  logic [31:0]  dcache_din;
  logic         dcache_re;
  logic [3:0]   dcache_we;
  logic [31:0]  dcache_dout;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic [15:0]  mem_req_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  dmem_cache #(.LINES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .dcache_addr    (dcache_addr),
    .dcache_din     (dcache_din),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [127:0] BASE_LINE = 128'h44444444_33333333_22222222_11111111;

  int           checks   = 0;
  int           failures = 0;
  int           exp_hits = 0;
  int           exp_misses = 0;
  logic [31:0]  last_dout = '0;
  logic [31:0]  sb_q[$];
  logic [127:0] mem_model [logic [27:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Untouched lines: line 0x100 holds the base pattern, others are perturbed by address.
  function automatic logic [127:0] line_of(input logic [27:0] l);
    logic [27:0] d;
    if (mem_model.exists(l)) return mem_model[l];
    d = l - 28'h0000100;
    return BASE_LINE ^ {4{{4'h0, d}}};
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, "_hits"},   hit_count,  STATS ? exp_hits : 0);
    chk({tag, "_misses"}, miss_count, STATS ? exp_misses : 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input bit exp_miss, input string tag);
    logic [127:0] ln;
    logic [31:0]  exp_w;
    int           n;
    ln    = line_of(addr[31:4]);
    exp_w = ln[addr[3:2]*32 +: 32];
    sb_q.push_back(exp_w);
    @(negedge clk);
    dcache_addr = addr;
    dcache_re   = 1'b1;
    #1;
    chk({tag, "_stall"}, stall, exp_miss);
    if (exp_miss) begin
      exp_misses++;
      n = 0;
      while (!mem_req_valid && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk({tag, "_req_valid"}, mem_req_valid, 1'b1);
      chk({tag, "_req_rw"},    mem_req_rw,    1'b0);
      chk({tag, "_req_addr"},  mem_req_addr,  addr[31:4]);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = ln;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #1;
      chk({tag, "_replay_stall"}, stall, 1'b0);
    end else begin
      exp_hits++;
    end
    @(negedge clk);
    dcache_re = 1'b0;
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      chk({tag, "_dout"}, dcache_dout, sb_q.pop_front());
    end
    last_dout = exp_w;
    check_counters(tag);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                          input int delay, input bit also_re, input string tag);
    logic [127:0] exp_data;
    logic [15:0]  exp_mask;
    logic [127:0] ln;
    int           n;
    exp_data = {96'b0, din} << (addr[3:2] * 32);
    exp_mask = {12'b0, we} << (addr[3:2] * 4);
    @(negedge clk);
    dcache_addr = addr;
    dcache_din  = din;
    dcache_we   = we;
    dcache_re   = also_re;
    #1;
    chk({tag, "_stall"}, stall, 1'b1);
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_req_valid"}, mem_req_valid, 1'b1);
    chk({tag, "_req_rw"},    mem_req_rw,    1'b1);
    chk({tag, "_req_addr"},  mem_req_addr,  addr[31:4]);
    chk({tag, "_req_data"},  mem_req_data,  exp_data);
    chk({tag, "_req_mask"},  mem_req_mask,  exp_mask);
    for (int c = 0; c < delay; c++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_stall"}, stall, 1'b1);
      chk({tag, "_hold_valid"}, mem_req_valid, 1'b1);
      chk({tag, "_hold_body"},  {mem_req_rw, mem_req_addr, mem_req_mask, mem_req_data},
                                {1'b1, addr[31:4], exp_mask, exp_data});
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk({tag, "_done_stall"}, stall, 1'b0);
    chk({tag, "_done_valid"}, mem_req_valid, 1'b0);
    ln = line_of(addr[31:4]);
    for (int b = 0; b < 16; b++) begin
      if (exp_mask[b]) ln[b*8 +: 8] = exp_data[b*8 +: 8];
    end
    mem_model[addr[31:4]] = ln;
    dcache_we  = 4'b0;
    dcache_re  = 1'b0;
    dcache_din = '0;
    @(negedge clk); #1;
    chk({tag, "_retired_stall"}, stall, 1'b0);
    chk({tag, "_retired_valid"}, mem_req_valid, 1'b0);
  endtask

  initial begin
    reset          = 1'b0;
    dcache_addr    = '0;
    dcache_din     = '0;
    dcache_re      = 1'b0;
    dcache_we      = 4'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    chk("rst_dout",  dcache_dout,   32'h0);
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_stall", stall,         1'b0);
    check_counters("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_read(32'h0000_1004, 1'b1, "cold_read");
    chk("cold_value", last_dout, 32'h2222_2222);
    do_read(32'h0000_1008, 1'b0, "repeat_hit");
    do_store(32'h0000_1004, 4'b0100, 32'h00AB_0000, 0, 1'b0, "store_hit");
    do_read(32'h0000_1004, 1'b0, "merged_read");
    chk("merged_value", last_dout, 32'h22AB_2222);
    do_store(32'h0000_1008, 4'b0011, 32'h0000_BEEF, 2, 1'b1, "store_over_read");
    do_read(32'h0000_1008, 1'b0, "merged_read2");

    // Idle cycles: no stall and dout holds.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("idle_stall", stall, 1'b0);
      chk("idle_dout",  dcache_dout, last_dout);
    end

    do_store(32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 5, 1'b0, "store_miss");
    do_read(32'h0000_2000, 1'b1, "no_allocate");
    do_read(32'h0000_100C, 1'b1, "evicted");
    do_read(32'h0001_1000, 1'b1, "alias");
    do_read(32'h0000_1000, 1'b1, "alias_back");

    // Reset while waiting for a fill, then a stray late response.
    @(negedge clk);
    dcache_addr = 32'h0000_3000;
    dcache_re   = 1'b1;
    #1;
    chk("abort_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("abort_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("abort_wait_stall", stall, 1'b1);
    reset     = 1'b0;
    dcache_re = 1'b0;
    #1;
    chk("abort_rst_stall", stall,         1'b0);
    chk("abort_rst_valid", mem_req_valid, 1'b0);
    chk("abort_rst_dout",  dcache_dout,   32'h0);
    exp_hits   = 0;
    exp_misses = 0;
    last_dout  = '0;
    check_counters("abort_rst");
    @(negedge clk);
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    #1;
    chk("late_resp_stall", stall, 1'b0);
    do_read(32'h0000_3000, 1'b1, "after_abort");
    do_read(32'h0000_3004, 1'b0, "after_abort_hit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
